btn_event_gen: RTL and testbench

//  Converts the debounced button levels (config/inc/dec) into single-cycle command pulses for the watch FSM.

---
 rtl/watch_pkg.sv | 15 +
 rtl/btn_step_fsm.sv | 115 +++++++++++
 rtl/btn_event_gen.sv | 111 +++++++++++
 tb/tb_btn_event_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types for the watch button front end: step/config FSM states and the
// hold-counter width helper used by btn_event_gen and btn_step_fsm.
package watch_pkg;

    typedef enum logic [1:0] {IDLE, HELD, REPEAT, LOCK} step_state_t;
    typedef enum logic [1:0] {C_IDLE, C_HELD, C_LONGDONE} cfg_state_t;

    function automatic int unsigned holdCntWidth(input int unsigned longCyc,
                                                 input int unsigned repeatCyc);
        int unsigned maxCyc;
        maxCyc = (longCyc > repeatCyc) ? longCyc : repeatCyc;
        return $clog2(maxCyc + 1);
    endfunction

endpackage

// File: rtl/btn_step_fsm.sv
// Press/auto-repeat step generator for one inc or dec button.
// Auto-repeat (REPEAT state and its counter) exists only when BTN_AUTO_REPEAT_EN is defined.
module btn_step_fsm
`ifdef BTN_AUTO_REPEAT_EN
#(
    parameter int unsigned LONG_CYC   = 100_000_000,
    parameter int unsigned REPEAT_CYC = 20_000_000
)
`endif
(
    input  logic clk_100MHz_i,
    input  logic reset_i,
    input  logic level_i,
    input  logic lock_i,
    output logic step_o
);
    import watch_pkg::*;

    step_state_t state_q, state_d;
    logic        prev_q;
    logic        step_q, step_d;
    logic        rise;

    assign rise   = level_i & ~prev_q;
    assign step_o = step_q;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned     CntW       = holdCntWidth(LONG_CYC, REPEAT_CYC);
    localparam logic [CntW-1:0] LongLast   = CntW'(LONG_CYC - 1);
    localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYC - 1);
    localparam logic [CntW-1:0] CntMax     = '1;

    logic [CntW-1:0] cnt_q, cnt_d, cntInc;

    assign cntInc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
`endif

    // A conflict overrides every state; the button must be released to leave LOCK.
    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        cnt_d   = cnt_q;
`endif
        if (lock_i) begin
            state_d = LOCK;
`ifdef BTN_AUTO_REPEAT_EN
            cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HELD;
                        step_d  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        cnt_d   = '0;
`endif
                    end
                end
                HELD: begin
                    if (!level_i) begin
                        state_d = IDLE;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    else if (cntInc >= LongLast) begin
                        state_d = REPEAT;
                        step_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cntInc;
                    end
`endif
                end
`ifdef BTN_AUTO_REPEAT_EN
                REPEAT: begin
                    if (!level_i) begin
                        state_d = IDLE;
                    end else if (cnt_q >= RepeatLast) begin
                        step_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
`endif
                LOCK: begin
                    if (!level_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            prev_q  <= 1'b1;
            step_q  <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            prev_q  <= level_i;
            step_q  <= step_d;
`ifdef BTN_AUTO_REPEAT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: rtl/btn_event_gen.sv
// Turns debounced config/inc/dec levels into single-cycle command pulses for watch.
// BTN_AUTO_REPEAT_EN enables hold-to-repeat on inc/dec; config short/long is the same in both builds.
module btn_event_gen #(
    parameter int unsigned LONG_CYC   = 100_000_000,
    parameter int unsigned REPEAT_CYC = 20_000_000
) (
    input  logic clk_100MHz_i,
    input  logic reset_i,
    input  logic btn_config_i,
    input  logic btn_inc_i,
    input  logic btn_dec_i,
    output logic cfg_short_o,
    output logic cfg_long_o,
    output logic inc_step_o,
    output logic dec_step_o
);
    import watch_pkg::*;

    localparam int unsigned     CntW     = holdCntWidth(LONG_CYC, REPEAT_CYC);
    localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYC - 1);
    localparam logic [CntW-1:0] CntMax   = '1;

    cfg_state_t      cfgState_q, cfgState_d;
    logic            cfgPrev_q;
    logic [CntW-1:0] cfgCnt_q, cfgCnt_d, cfgCntInc;
    logic            cfgShort_q, cfgShort_d;
    logic            cfgLong_q, cfgLong_d;
    logic            cfgRise;
    logic            incDecConflict;

    assign cfgRise        = btn_config_i & ~cfgPrev_q;
    assign cfgCntInc      = (cfgCnt_q == CntMax) ? cfgCnt_q : cfgCnt_q + CntW'(1);
    assign incDecConflict = btn_inc_i & btn_dec_i;
    assign cfg_short_o    = cfgShort_q;
    assign cfg_long_o     = cfgLong_q;

    // Once the long pulse has fired, LONGDONE swallows the release so no short follows.
    always_comb begin
        cfgState_d = cfgState_q;
        cfgCnt_d   = cfgCnt_q;
        cfgShort_d = 1'b0;
        cfgLong_d  = 1'b0;
        case (cfgState_q)
            C_IDLE: begin
                if (cfgRise) begin
                    cfgState_d = C_HELD;
                    cfgCnt_d   = '0;
                end
            end
            C_HELD: begin
                if (!btn_config_i) begin
                    cfgShort_d = (cfgCnt_q < LongLast);
                    cfgState_d = C_IDLE;
                end else if (cfgCntInc >= LongLast) begin
                    cfgLong_d  = 1'b1;
                    cfgState_d = C_LONGDONE;
                    cfgCnt_d   = cfgCntInc;
                end else begin
                    cfgCnt_d = cfgCntInc;
                end
            end
            C_LONGDONE: begin
                if (!btn_config_i) begin
                    cfgState_d = C_IDLE;
                end
            end
            default: cfgState_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz_i) begin
        if (reset_i) begin
            cfgState_q <= C_IDLE;
            cfgPrev_q  <= 1'b1;
            cfgCnt_q   <= '0;
            cfgShort_q <= 1'b0;
            cfgLong_q  <= 1'b0;
        end else begin
            cfgState_q <= cfgState_d;
            cfgPrev_q  <= btn_config_i;
            cfgCnt_q   <= cfgCnt_d;
            cfgShort_q <= cfgShort_d;
            cfgLong_q  <= cfgLong_d;
        end
    end

    btn_step_fsm
`ifdef BTN_AUTO_REPEAT_EN
        #(.LONG_CYC(LONG_CYC), .REPEAT_CYC(REPEAT_CYC))
`endif
        u_incFsm (
            .clk_100MHz_i (clk_100MHz_i),
            .reset_i      (reset_i),
            .level_i      (btn_inc_i),
            .lock_i       (incDecConflict),
            .step_o       (inc_step_o)
        );

    btn_step_fsm
`ifdef BTN_AUTO_REPEAT_EN
        #(.LONG_CYC(LONG_CYC), .REPEAT_CYC(REPEAT_CYC))
`endif
        u_decFsm (
            .clk_100MHz_i (clk_100MHz_i),
            .reset_i      (reset_i),
            .level_i      (btn_dec_i),
            .lock_i       (incDecConflict),
            .step_o       (dec_step_o)
        );

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: directed scenarios plus random button traffic, each cycle
// compared against a press-time based reference model (honours BTN_AUTO_REPEAT_EN).
module tb_btn_event_gen;

    localparam int LongCyc   = 10;
    localparam int RepeatCyc = 4;

    logic clk = 1'b0;
    logic reset, btnConfig, btnInc, btnDec;
    logic cfgShort, cfgLong, incStep, decStep;

    always #5 clk = ~clk;

    btn_event_gen #(
        .LONG_CYC   (LongCyc),
        .REPEAT_CYC (RepeatCyc)
    ) dut (
        .clk_100MHz_i (clk),
        .reset_i      (reset),
        .btn_config_i (btnConfig),
        .btn_inc_i    (btnInc),
        .btn_dec_i    (btnDec),
        .cfg_short_o  (cfgShort),
        .cfg_long_o   (cfgLong),
        .inc_step_o   (incStep),
        .dec_step_o   (decStep)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: remembers the edge index of the live press of each button.
    int edgeIdx  = 0;
    bit mCfgPrev = 1'b1;
    bit mIncPrev = 1'b1;
    bit mDecPrev = 1'b1;
    int cfgPress = -1;
    int incPress = -1;
    int decPress = -1;
    bit expShort, expLong, expInc, expDec;

    int seenShort, seenLong, seenInc, seenDec;

    function automatic bit stepDue(input int held);
`ifdef BTN_AUTO_REPEAT_EN
        if (held == LongCyc - 1) return 1'b1;
        if (held > LongCyc - 1 && ((held - (LongCyc - 1)) % RepeatCyc) == 0) return 1'b1;
`endif
        return (held < 0);
    endfunction

    task automatic updateStep(input bit level, input bit conflict, input bit prev,
                              inout int press, output bit due);
        due = 1'b0;
        if (conflict) begin
            press = -1;
        end else if (press >= 0) begin
            if (!level) press = -1;
            else due = stepDue(edgeIdx - press);
        end else if (level && !prev) begin
            press = edgeIdx;
            due   = 1'b1;
        end
    endtask

    task automatic modelStep(input bit rst, input bit cfg, input bit inc, input bit dec);
        expShort = 1'b0;
        expLong  = 1'b0;
        expInc   = 1'b0;
        expDec   = 1'b0;
        if (rst) begin
            mCfgPrev = 1'b1;
            mIncPrev = 1'b1;
            mDecPrev = 1'b1;
            cfgPress = -1;
            incPress = -1;
            decPress = -1;
        end else begin
            if (cfgPress >= 0) begin
                if (!cfg) begin
                    expShort = 1'b1;
                    cfgPress = -1;
                end else if (edgeIdx - cfgPress == LongCyc - 1) begin
                    expLong  = 1'b1;
                    cfgPress = -1;
                end
            end else if (cfg && !mCfgPrev) begin
                cfgPress = edgeIdx;
            end
            updateStep(inc, inc && dec, mIncPrev, incPress, expInc);
            updateStep(dec, inc && dec, mDecPrev, decPress, expDec);
            mCfgPrev = cfg;
            mIncPrev = inc;
            mDecPrev = dec;
        end
        edgeIdx++;
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s edge=%0d observed=%b expected=%b", tag, edgeIdx, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed == expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkBit("cfg_short", cfgShort, expShort);
        checkBit("cfg_long",  cfgLong,  expLong);
        checkBit("inc_step",  incStep,  expInc);
        checkBit("dec_step",  decStep,  expDec);
        if (cfgShort === 1'b1) seenShort++;
        if (cfgLong  === 1'b1) seenLong++;
        if (incStep  === 1'b1) seenInc++;
        if (decStep  === 1'b1) seenDec++;
    endtask

    task automatic applyStimulus(input bit rst, input bit cfg, input bit inc, input bit dec,
                                 input int cycles);
        for (int i = 0; i < cycles; i++) begin
            reset     = rst;
            btnConfig = cfg;
            btnInc    = inc;
            btnDec    = dec;
            @(posedge clk);
            modelStep(rst, cfg, inc, dec);
            #1;
            checkOutput();
        end
    endtask

    task automatic clearCounts();
        seenShort = 0;
        seenLong  = 0;
        seenInc   = 0;
        seenDec   = 0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int expRepeatPulses;
`ifdef BTN_AUTO_REPEAT_EN
        expRepeatPulses = 5;
`else
        expRepeatPulses = 1;
`endif
        clearCounts();

        // 1: reset, then a short config press
        applyStimulus(1, 0, 0, 0, 3);
        checkCount("reset_pulses", seenShort + seenLong + seenInc + seenDec, 0);
        applyStimulus(0, 0, 0, 0, 2);
        clearCounts();
        applyStimulus(0, 1, 0, 0, 3);
        applyStimulus(0, 0, 0, 0, 3);
        checkCount("short_count", seenShort, 1);
        checkCount("short_no_long", seenLong, 0);

        // 2: long config press, release gives nothing
        clearCounts();
        applyStimulus(0, 1, 0, 0, 25);
        applyStimulus(0, 0, 0, 0, 3);
        checkCount("long_count", seenLong, 1);
        checkCount("long_no_short", seenShort, 0);

        // 3: inc held 22 cycles
        clearCounts();
        applyStimulus(0, 0, 1, 0, 22);
        applyStimulus(0, 0, 0, 0, 3);
        checkCount("repeat_count", seenInc, expRepeatPulses);

        // 4: dec joins a held inc, then is released alone
        clearCounts();
        applyStimulus(0, 0, 1, 0, 5);
        checkCount("pre_lock_inc", seenInc, 1);
        clearCounts();
        applyStimulus(0, 0, 1, 1, 6);
        applyStimulus(0, 0, 1, 0, 10);
        checkCount("locked_inc", seenInc, 0);
        checkCount("locked_dec", seenDec, 0);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 2);
        checkCount("relock_inc", seenInc, 1);

        // 5: simultaneous rise, then dec alone
        clearCounts();
        applyStimulus(0, 0, 1, 1, 3);
        applyStimulus(0, 0, 0, 0, 2);
        checkCount("same_rise_inc", seenInc, 0);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 2);
        checkCount("dec_alone", seenDec, 1);

        // 6: inc held through reset; config rising at reset release; reset mid config hold
        applyStimulus(0, 0, 1, 0, 3);
        applyStimulus(1, 0, 1, 0, 2);
        clearCounts();
        applyStimulus(0, 0, 1, 0, 5);
        checkCount("held_thru_reset", seenInc, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 2);
        checkCount("repress_after_reset", seenInc, 1);
        clearCounts();
        applyStimulus(1, 0, 0, 0, 2);
        applyStimulus(0, 1, 0, 0, 15);
        applyStimulus(0, 0, 0, 0, 2);
        checkCount("cfg_at_reset_release", seenShort + seenLong, 0);
        applyStimulus(0, 1, 0, 0, 9);
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 12);
        applyStimulus(0, 0, 0, 0, 2);
        checkCount("cfg_reset_mid_hold", seenShort + seenLong, 0);

        // Random traffic against the model
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(15) == 0) begin
                applyStimulus(1, 1'($urandom_range(1)), 1'($urandom_range(1)),
                              1'($urandom_range(1)), $urandom_range(2, 1));
            end else begin
                applyStimulus(0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                              1'($urandom_range(3) == 0), $urandom_range(14, 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
